// File: rtl/board_elimination_manager.sv
// 3x3 board state with per-player oldest-piece elimination, win detection and
// a "next piece to fade" indicator for the display.
module board_elimination_manager #(
    parameter int MAX_MARKS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] location,
    input  logic [1:0] mark,
    output logic [1:0] a0,
    output logic [1:0] a1,
    output logic [1:0] a2,
    output logic [1:0] a3,
    output logic [1:0] a4,
    output logic [1:0] a5,
    output logic [1:0] a6,
    output logic [1:0] a7,
    output logic [1:0] a8,
    output logic [1:0] winner,
    output logic       game_over,
    output logic [3:0] fading_loc,
    output logic       fading_valid,
    output logic [7:0] move_count
);

    localparam int CW = $clog2(MAX_MARKS + 1);
    localparam logic [CW-1:0] FULL = CW'(MAX_MARKS);
    localparam logic [1:0] P_X = 2'b10;
    localparam logic [1:0] P_O = 2'b01;

    logic [1:0]    cell_q [9];
    logic [1:0]    cell_d [9];
    logic [3:0]    xq_q [MAX_MARKS];
    logic [3:0]    xq_d [MAX_MARKS];
    logic [3:0]    oq_q [MAX_MARKS];
    logic [3:0]    oq_d [MAX_MARKS];
    logic [CW-1:0] xcnt_q, xcnt_d, ocnt_q, ocnt_d;
    logic [1:0]    last_q, last_d;
    logic [1:0]    winner_q, winner_d;
    logic          game_over_q, game_over_d;
    logic [3:0]    fading_loc_q, fading_loc_d;
    logic          fading_valid_q, fading_valid_d;
    logic [7:0]    move_count_q, move_count_d;

    logic          occupied, accept, x_win, o_win;
    logic [1:0]    ln [8];

    function automatic logic [1:0] line3(input logic [1:0] p, input logic [1:0] q,
                                         input logic [1:0] r);
        return (p == q && q == r) ? p : 2'b00;
    endfunction

    always_comb begin
        cell_d         = cell_q;
        xq_d           = xq_q;
        oq_d           = oq_q;
        xcnt_d         = xcnt_q;
        ocnt_d         = ocnt_q;
        last_d         = last_q;
        winner_d       = winner_q;
        game_over_d    = game_over_q;
        move_count_d   = move_count_q;
        fading_loc_d   = fading_loc_q;
        fading_valid_d = fading_valid_q;
        occupied       = 1'b0;
        x_win          = 1'b0;
        o_win          = 1'b0;

        // Out-of-range locations match no cell, so they never look "empty".
        occupied = 1'b1;
        for (int i = 0; i < 9; i++)
            if (location == 4'(i)) occupied = (cell_q[i] != 2'b00);

        accept = (mark == P_X || mark == P_O) && !occupied && !game_over_q;

        if (accept) begin
            if (mark == P_X) begin
                if (xcnt_q == FULL) begin
                    for (int i = 0; i < 9; i++)
                        if (xq_q[0] == 4'(i)) cell_d[i] = 2'b00;
                    for (int k = 0; k < MAX_MARKS - 1; k++) xq_d[k] = xq_q[k+1];
                    xq_d[MAX_MARKS-1] = location;
                end else begin
                    for (int k = 0; k < MAX_MARKS; k++)
                        if (xcnt_q == CW'(k)) xq_d[k] = location;
                    xcnt_d = xcnt_q + 1'b1;
                end
            end else begin
                if (ocnt_q == FULL) begin
                    for (int i = 0; i < 9; i++)
                        if (oq_q[0] == 4'(i)) cell_d[i] = 2'b00;
                    for (int k = 0; k < MAX_MARKS - 1; k++) oq_d[k] = oq_q[k+1];
                    oq_d[MAX_MARKS-1] = location;
                end else begin
                    for (int k = 0; k < MAX_MARKS; k++)
                        if (ocnt_q == CW'(k)) oq_d[k] = location;
                    ocnt_d = ocnt_q + 1'b1;
                end
            end
            for (int i = 0; i < 9; i++)
                if (location == 4'(i)) cell_d[i] = mark;
            last_d       = mark;
            move_count_d = (move_count_q == 8'hFF) ? move_count_q : move_count_q + 8'd1;
        end

        // Lines are evaluated on the post-elimination board.
        ln[0] = line3(cell_d[0], cell_d[1], cell_d[2]);
        ln[1] = line3(cell_d[3], cell_d[4], cell_d[5]);
        ln[2] = line3(cell_d[6], cell_d[7], cell_d[8]);
        ln[3] = line3(cell_d[0], cell_d[3], cell_d[6]);
        ln[4] = line3(cell_d[1], cell_d[4], cell_d[7]);
        ln[5] = line3(cell_d[2], cell_d[5], cell_d[8]);
        ln[6] = line3(cell_d[0], cell_d[4], cell_d[8]);
        ln[7] = line3(cell_d[2], cell_d[4], cell_d[6]);
        for (int l = 0; l < 8; l++) begin
            if (ln[l] == P_X) x_win = 1'b1;
            if (ln[l] == P_O) o_win = 1'b1;
        end

        if (accept) begin
            if (x_win) begin
                winner_d    = P_X;
                game_over_d = 1'b1;
            end else if (o_win) begin
                winner_d    = P_O;
                game_over_d = 1'b1;
            end

            fading_valid_d = 1'b0;
            fading_loc_d   = 4'd0;
            if (!game_over_d) begin
                if (last_d == P_X && ocnt_d == FULL) begin
                    fading_valid_d = 1'b1;
                    fading_loc_d   = oq_d[0];
                end else if (last_d == P_O && xcnt_d == FULL) begin
                    fading_valid_d = 1'b1;
                    fading_loc_d   = xq_d[0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 9; i++) cell_q[i] <= 2'b00;
            for (int k = 0; k < MAX_MARKS; k++) begin
                xq_q[k] <= 4'd0;
                oq_q[k] <= 4'd0;
            end
            xcnt_q         <= '0;
            ocnt_q         <= '0;
            last_q         <= 2'b00;
            winner_q       <= 2'b00;
            game_over_q    <= 1'b0;
            fading_loc_q   <= 4'd0;
            fading_valid_q <= 1'b0;
            move_count_q   <= 8'd0;
        end else begin
            cell_q         <= cell_d;
            xq_q           <= xq_d;
            oq_q           <= oq_d;
            xcnt_q         <= xcnt_d;
            ocnt_q         <= ocnt_d;
            last_q         <= last_d;
            winner_q       <= winner_d;
            game_over_q    <= game_over_d;
            fading_loc_q   <= fading_loc_d;
            fading_valid_q <= fading_valid_d;
            move_count_q   <= move_count_d;
        end
    end

    assign a0           = cell_q[0];
    assign a1           = cell_q[1];
    assign a2           = cell_q[2];
    assign a3           = cell_q[3];
    assign a4           = cell_q[4];
    assign a5           = cell_q[5];
    assign a6           = cell_q[6];
    assign a7           = cell_q[7];
    assign a8           = cell_q[8];
    assign winner       = winner_q;
    assign game_over    = game_over_q;
    assign fading_loc   = fading_loc_q;
    assign fading_valid = fading_valid_q;
    assign move_count   = move_count_q;

endmodule

// File: tb/tb_board_elimination_manager.sv
// Directed bench for board_elimination_manager; board compared as {a8..a0}.
module tb_board_elimination_manager;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] location = 4'd0;
    logic [1:0] mark = 2'b00;
    logic [1:0] a0, a1, a2, a3, a4, a5, a6, a7, a8, winner;
    logic       game_over, fading_valid;
    logic [3:0] fading_loc;
    logic [7:0] move_count;
    int         passed = 0;
    int         total = 0;

    localparam logic [1:0] X = 2'b10;
    localparam logic [1:0] O = 2'b01;

    board_elimination_manager #(.MAX_MARKS(3)) dut (
        .clk(clk), .rst(rst), .location(location), .mark(mark),
        .a0(a0), .a1(a1), .a2(a2), .a3(a3), .a4(a4), .a5(a5), .a6(a6), .a7(a7), .a8(a8),
        .winner(winner), .game_over(game_over), .fading_loc(fading_loc),
        .fading_valid(fading_valid), .move_count(move_count)
    );

    always #5 clk = ~clk;

    wire [17:0] board = {a8, a7, a6, a5, a4, a3, a2, a1, a0};

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One-cycle mark pulse; returns on the negedge after the capturing edge.
    task automatic do_move(input logic [1:0] m, input logic [3:0] l);
        @(negedge clk);
        mark = m;
        location = l;
        @(negedge clk);
        mark = 2'b00;
    endtask

    task automatic test_reset();
        total++; if (board !== 18'd0) $display("FAIL reset_board got %h exp 0", board); else passed++;
        total++; if ({winner, game_over, fading_valid} !== 4'b0) $display("FAIL reset_flags got %b exp 0000", {winner, game_over, fading_valid}); else passed++;
        total++; if ({move_count, fading_loc} !== 12'd0) $display("FAIL reset_counts got %h exp 000", {move_count, fading_loc}); else passed++;
    endtask

    task automatic test_basic();
        do_reset();
        do_move(X, 4);
        total++; if (board !== 18'b00_00_00_00_10_00_00_00_00) $display("FAIL basic_x4 got %b", board); else passed++;
        do_move(O, 0);
        total++; if (board !== 18'b00_00_00_00_10_00_00_00_01) $display("FAIL basic_o0 got %b", board); else passed++;
        do_move(X, 8);
        total++; if (board !== 18'b10_00_00_00_10_00_00_00_01) $display("FAIL basic_x8 got %b", board); else passed++;
        total++; if (move_count !== 8'd3) $display("FAIL basic_count got %0d exp 3", move_count); else passed++;
        total++; if ({winner, fading_valid} !== 3'b000) $display("FAIL basic_flags got %b exp 000", {winner, fading_valid}); else passed++;
    endtask

    task automatic test_elimination();
        do_reset();
        do_move(X, 0); do_move(O, 3); do_move(X, 1);
        do_move(O, 4); do_move(X, 6); do_move(O, 7);
        total++; if (board !== 18'b00_01_10_00_01_01_00_10_10) $display("FAIL elim_pre_board got %b", board); else passed++;
        total++; if ({fading_valid, fading_loc} !== 5'b1_0000) $display("FAIL elim_fade_x got %b exp 10000", {fading_valid, fading_loc}); else passed++;
        do_move(X, 5);
        total++; if (board !== 18'b00_01_10_10_01_01_00_10_00) $display("FAIL elim_post_board got %b", board); else passed++;
        total++; if ({fading_valid, fading_loc} !== 5'b1_0011) $display("FAIL elim_fade_o got %b exp 10011", {fading_valid, fading_loc}); else passed++;
        total++; if ({move_count, winner} !== {8'd7, 2'b00}) $display("FAIL elim_count got %0d/%b exp 7/00", move_count, winner); else passed++;
    endtask

    task automatic test_win_freeze();
        do_reset();
        do_move(X, 0); do_move(O, 3); do_move(X, 1); do_move(O, 4); do_move(X, 2);
        total++; if ({winner, game_over, fading_valid} !== 4'b10_1_0) $display("FAIL win_flags got %b exp 1010", {winner, game_over, fading_valid}); else passed++;
        do_move(X, 8);
        total++; if (board !== 18'b00_00_00_00_01_01_10_10_10) $display("FAIL win_frozen_board got %b", board); else passed++;
        total++; if (move_count !== 8'd5) $display("FAIL win_frozen_count got %0d exp 5", move_count); else passed++;
    endtask

    task automatic test_hold_and_invalid();
        do_reset();
        @(negedge clk);
        mark = X; location = 2;
        repeat (5) @(negedge clk);
        mark = 2'b00;
        total++; if (board !== 18'b00_00_00_00_00_00_10_00_00) $display("FAIL hold_board got %b", board); else passed++;
        total++; if (move_count !== 8'd1) $display("FAIL hold_count got %0d exp 1", move_count); else passed++;
        do_move(2'b11, 5);
        do_move(O, 12);
        total++; if (board !== 18'b00_00_00_00_00_00_10_00_00) $display("FAIL invalid_board got %b", board); else passed++;
        total++; if (move_count !== 8'd1) $display("FAIL invalid_count got %0d exp 1", move_count); else passed++;
    endtask

    task automatic test_post_elim_win();
        // Row 012 completes after the oldest X (8) is removed.
        do_reset();
        do_move(X, 8); do_move(X, 0); do_move(X, 1); do_move(X, 2);
        total++; if (board !== 18'b00_00_00_00_00_00_10_10_10) $display("FAIL pe_win_board got %b", board); else passed++;
        total++; if ({winner, game_over} !== 3'b10_1) $display("FAIL pe_win_flags got %b exp 101", {winner, game_over}); else passed++;
        // Diagonal 246 would form only if 2 were not eliminated first.
        do_reset();
        do_move(X, 2); do_move(X, 4); do_move(X, 1); do_move(X, 6);
        total++; if (board !== 18'b00_00_10_00_10_00_00_10_00) $display("FAIL pe_nowin_board got %b", board); else passed++;
        total++; if ({winner, game_over, fading_valid} !== 4'b00_0_0) $display("FAIL pe_nowin_flags got %b exp 0000", {winner, game_over, fading_valid}); else passed++;
        total++; if (move_count !== 8'd4) $display("FAIL pe_nowin_count got %0d exp 4", move_count); else passed++;
    endtask

    task automatic test_async_reset();
        do_reset();
        do_move(X, 0); do_move(O, 3); do_move(X, 1);
        do_move(O, 4); do_move(X, 6); do_move(O, 7);
        total++; if (fading_valid !== 1'b1) $display("FAIL ar_pre_fade got %b exp 1", fading_valid); else passed++;
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        total++; if (board !== 18'd0) $display("FAIL ar_board got %b exp 0", board); else passed++;
        total++; if ({winner, game_over, fading_valid, move_count} !== 12'd0) $display("FAIL ar_flags got %b exp 0", {winner, game_over, fading_valid, move_count}); else passed++;
        @(negedge clk);
        rst = 1'b1;
        do_move(X, 4);
        total++; if (board !== 18'b00_00_00_00_10_00_00_00_00) $display("FAIL ar_after_board got %b", board); else passed++;
        total++; if (move_count !== 8'd1) $display("FAIL ar_after_count got %0d exp 1", move_count); else passed++;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b1;
        test_basic();
        test_elimination();
        test_win_freeze();
        test_hold_and_invalid();
        test_post_elim_win();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
